// File: rtl/bbox_msg_pkg.sv
// Shared definitions for the bounding-box message arbiter.
//   state_t      : burst FSM states
//   COORD_W      : coordinate width
//   PAD_W, ID_W  : zero-pad width inside a coordinate word, tracker ID width
//   ID_*         : default 3-character tracker IDs
//   pack_xy()    : builds a {pad, x, pad, y} FIFO word
package bbox_msg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    TL   = 2'd2,
    BR   = 2'd3
  } state_t;

  localparam int COORD_W = 11;
  localparam int PAD_W   = 5;
  localparam int ID_W    = 24;

  localparam logic [ID_W-1:0] ID_RED    = "RBB";
  localparam logic [ID_W-1:0] ID_YELLOW = "YBB";
  localparam logic [ID_W-1:0] ID_BLUE   = "BBB";
  localparam logic [ID_W-1:0] ID_WHITE  = "WBB";

  function automatic logic [31:0] pack_xy(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y);
    return {{PAD_W{1'b0}}, x, {PAD_W{1'b0}}, y};
  endfunction

endpackage

// File: rtl/bbox_msg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// rr_ptr, wrapping modulo N_REQ.
//   req    : request vector
//   rr_ptr : highest-priority index this decision
//   grant  : one-hot winner
//   winner : binary winner index
//   valid  : any request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        winner     = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bbox_msg_arbiter.sv
// Shares one 32-bit CPU message FIFO between N_REQ bounding-box trackers.
// Each granted request is written as an atomic 3-word burst:
// {8'h00, id}, {pad, x_min, pad, y_min}, {pad, x_max, pad, y_max}.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : level request per tracker, held until its ack
//   req_id       : 24-bit ID per tracker, tracker i at [24i+23:24i]
//   req_box      : {x_min, y_min, x_max, y_max} per tracker
//   ack          : one-cycle pulse when a message is written or suppressed
//   busy         : burst in progress
//   fifo_wr      : FIFO write strobe
//   fifo_data    : FIFO write word
//   fifo_usedw   : FIFO fill level
//   fifo_flush   : FIFO is being cleared this cycle
module bbox_msg_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 256,
  parameter int COORD_W    = 11,
  parameter int USEDW_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*24-1:0]      req_id,
  input  logic [N_REQ*4*COORD_W-1:0] req_box,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic                     fifo_wr,
  output logic [31:0]              fifo_data,
  input  logic [USEDW_W-1:0]       fifo_usedw,
  input  logic                     fifo_flush
);

  import bbox_msg_pkg::*;

  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BOX_W    = 4 * COORD_W;
  localparam int XMIN_LSB = 3 * COORD_W;
  localparam int YMIN_LSB = 2 * COORD_W;
  localparam int XMAX_LSB = COORD_W;
  localparam int YMAX_LSB = 0;
  // Need room for a whole burst plus one word of fifo_usedw lag.
  localparam logic [USEDW_W-1:0] ROOM = USEDW_W'(FIFO_DEPTH - 4);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]  win_q, winner;
  logic [N_REQ-1:0]  grant, req_live, ack_d;
  logic              valid, latch, empty, wr_d;
  logic [23:0]       id_q, sel_id;
  logic [BOX_W-1:0]  box_q, sel_box;
  logic [31:0]       data_d;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w);
    return (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  // A requester still holds req during its ack cycle; masking it there
  // prevents a second grant of the same message.
  assign req_live = req & ~ack;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (req_live),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .valid  (valid)
  );

  always_comb begin
    sel_id  = '0;
    sel_box = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == winner) begin
        sel_id  = req_id[i*24 +: 24];
        sel_box = req_box[i*BOX_W +: BOX_W];
      end
    end
  end

  assign empty = (sel_box[XMIN_LSB +: COORD_W] > sel_box[XMAX_LSB +: COORD_W]) ||
                 (sel_box[YMIN_LSB +: COORD_W] > sel_box[YMAX_LSB +: COORD_W]);

  // Next-state and next-output logic; outputs are registered on entry to
  // the state they belong to, so HDR/TL/BR words appear while in that state.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr;
    wr_d     = 1'b0;
    data_d   = fifo_data;
    ack_d    = '0;
    latch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_flush && valid) begin
          if (empty) begin
            ack_d    = grant;
            rr_ptr_d = ptr_after(winner);
          end else if (fifo_usedw < ROOM) begin
            latch   = 1'b1;
            state_d = HDR;
            wr_d    = 1'b1;
            data_d  = {8'h00, sel_id};
          end
        end
      end
      HDR: begin
        if (fifo_flush) begin
          state_d = IDLE;
        end else begin
          state_d = TL;
          wr_d    = 1'b1;
          data_d  = pack_xy(box_q[XMIN_LSB +: COORD_W], box_q[YMIN_LSB +: COORD_W]);
        end
      end
      TL: begin
        if (fifo_flush) begin
          state_d = IDLE;
        end else begin
          state_d  = BR;
          wr_d     = 1'b1;
          data_d   = pack_xy(box_q[XMAX_LSB +: COORD_W], box_q[YMAX_LSB +: COORD_W]);
          ack_d    = N_REQ'(1) << win_q;
          rr_ptr_d = ptr_after(win_q);
        end
      end
      BR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      win_q     <= '0;
      id_q      <= '0;
      box_q     <= '0;
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
      ack       <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_ptr_d;
      fifo_wr   <= wr_d;
      fifo_data <= data_d;
      ack       <= ack_d;
      busy      <= (state_d != IDLE);
      if (latch) begin
        win_q <= winner;
        id_q  <= sel_id;
        box_q <= sel_box;
      end
    end
  end

  // id_q documents the latched header; the header word itself is built from
  // sel_id in the grant cycle.
  logic unused_id;
  assign unused_id = ^id_q;

endmodule

// File: tb/tb_bbox_msg_arbiter.sv
module tb_bbox_msg_arbiter;
  import bbox_msg_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [95:0]  req_id;
  logic [175:0] req_box;
  logic [3:0]   ack;
  logic         busy;
  logic         fifo_wr;
  logic [31:0]  fifo_data;
  logic [7:0]   fifo_usedw;
  logic         fifo_flush;

  logic [37:0]  obs;
  logic [37:0]  exp;
  int n_cmp = 0;
  int n_bad = 0;

  assign obs = {ack, busy, fifo_wr, fifo_data};

  always #5 clk = ~clk;

  bbox_msg_arbiter #(
    .N_REQ(4), .FIFO_DEPTH(256), .COORD_W(11), .USEDW_W(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_id     (req_id),
    .req_box    (req_box),
    .ack        (ack),
    .busy       (busy),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .fifo_usedw (fifo_usedw),
    .fifo_flush (fifo_flush)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] mkbox(int xmn, int ymn, int xmx, int ymx);
    return {11'(xmn), 11'(ymn), 11'(xmx), 11'(ymx)};
  endfunction

  task automatic set_box(int i, logic [43:0] b);
    req_box[44*i +: 44] = b;
  endtask

  task automatic std_boxes();
    req_id = {ID_WHITE, ID_BLUE, ID_YELLOW, ID_RED};
    for (int i = 0; i < 4; i++) set_box(i, mkbox(10*i+1, 20*i+2, 10*i+5, 20*i+9));
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    req        = '0;
    fifo_flush = 1'b0;
    fifo_usedw = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    req        = 4'b1111;
    fifo_flush = 1'b0;
    fifo_usedw = '0;
    std_boxes();
    step();
    step();
    n_cmp++;
    if (obs !== 38'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 38'd0);
    end
    reset_n = 1'b1;
    req = '0;
    step();
    n_cmp++;
    if (obs[37:32] !== 6'b0) begin
      n_bad++; $display("FAIL reset_idle got=%b want=%b", obs[37:32], 6'b0);
    end
  endtask

  task automatic test_single();
    apply_reset();
    std_boxes();
    set_box(0, mkbox(10, 20, 30, 40));
    req = 4'b0001;
    step();
    exp = {4'b0000, 2'b11, 32'h00524242};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL single_hdr got=%h want=%h", obs, exp); end
    set_box(0, mkbox(1, 1, 2, 2));
    step();
    exp = {4'b0000, 2'b11, 32'h000A0014};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL single_tl got=%h want=%h", obs, exp); end
    step();
    exp = {4'b0001, 2'b11, 32'h001E0028};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL single_br got=%h want=%h", obs, exp); end
    req = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (obs[37:32] !== 6'b0) begin
        n_bad++; $display("FAIL single_idle%0d got=%b want=%b", c, obs[37:32], 6'b0);
      end
    end
  endtask

  task automatic test_fairness();
    logic [31:0] hdr_t [4] = '{32'h00524242, 32'h00594242, 32'h00424242, 32'h00574242};
    logic [31:0] tl_t  [4] = '{32'h00010002, 32'h000B0016, 32'h0015002A, 32'h001F003E};
    logic [31:0] br_t  [4] = '{32'h00050009, 32'h000F001D, 32'h00190031, 32'h00230045};
    int i;
    apply_reset();
    std_boxes();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      i = g % 4;
      step();
      exp = {4'b0000, 2'b11, hdr_t[i]};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL fair_hdr%0d got=%h want=%h", g, obs, exp); end
      step();
      exp = {4'b0000, 2'b11, tl_t[i]};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL fair_tl%0d got=%h want=%h", g, obs, exp); end
      step();
      exp = {4'(1 << i), 2'b11, br_t[i]};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL fair_br%0d got=%h want=%h", g, obs, exp); end
      step();
      n_cmp++;
      if (obs[37:32] !== 6'b0) begin
        n_bad++; $display("FAIL fair_gap%0d got=%b want=%b", g, obs[37:32], 6'b0);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_fifo_full();
    apply_reset();
    std_boxes();
    set_box(1, mkbox(100, 200, 300, 400));
    fifo_usedw = 8'd252;
    req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (obs[37:32] !== 6'b0) begin
        n_bad++; $display("FAIL full_hold%0d got=%b want=%b", c, obs[37:32], 6'b0);
      end
    end
    fifo_usedw = 8'd251;
    step();
    exp = {4'b0000, 2'b11, 32'h00594242};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL full_hdr got=%h want=%h", obs, exp); end
    step();
    exp = {4'b0000, 2'b11, 32'h006400C8};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL full_tl got=%h want=%h", obs, exp); end
    step();
    exp = {4'b0010, 2'b11, 32'h012C0190};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL full_br got=%h want=%h", obs, exp); end
    req = '0;
    fifo_usedw = '0;
    step();
  endtask

  task automatic test_empty_box();
    apply_reset();
    std_boxes();
    set_box(2, mkbox(639, 0, 0, 10));
    req = 4'b0100;
    step();
    n_cmp++;
    if (obs[37:32] !== 6'b010000) begin
      n_bad++; $display("FAIL empty_ack got=%b want=%b", obs[37:32], 6'b010000);
    end
    step();
    n_cmp++;
    if (obs[37:32] !== 6'b0) begin
      n_bad++; $display("FAIL empty_once got=%b want=%b", obs[37:32], 6'b0);
    end
    req = 4'b1011;
    step();
    exp = {4'b0000, 2'b11, 32'h00574242};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL empty_next_hdr got=%h want=%h", obs, exp); end
    step();
    step();
    exp = {4'b1000, 2'b11, 32'h00230045};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL empty_next_br got=%h want=%h", obs, exp); end
    req = '0;
    step();
  endtask

  task automatic test_flush_tl();
    apply_reset();
    std_boxes();
    req = 4'b0010;
    step();
    step();
    exp = {4'b0000, 2'b11, 32'h000B0016};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL flush_tl_word got=%h want=%h", obs, exp); end
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
    n_cmp++;
    if (obs[37:32] !== 6'b0) begin
      n_bad++; $display("FAIL flush_abort got=%b want=%b", obs[37:32], 6'b0);
    end
    step();
    exp = {4'b0000, 2'b11, 32'h00594242};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL flush_retry_hdr got=%h want=%h", obs, exp); end
    step();
    exp = {4'b0000, 2'b11, 32'h000B0016};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL flush_retry_tl got=%h want=%h", obs, exp); end
    step();
    exp = {4'b0010, 2'b11, 32'h000F001D};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL flush_retry_br got=%h want=%h", obs, exp); end
    req = '0;
    step();
  endtask

  task automatic test_async_reset();
    apply_reset();
    std_boxes();
    req = 4'b0001;
    step();
    step();
    step();
    req = 4'b0100;
    step();
    step();
    exp = {4'b0000, 2'b11, 32'h00424242};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL arst_pre_hdr got=%h want=%h", obs, exp); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 38'd0) begin n_bad++; $display("FAIL arst_outputs got=%h want=%h", obs, 38'd0); end
    req = 4'b1111;
    #2;
    reset_n = 1'b1;
    step();
    exp = {4'b0000, 2'b11, 32'h00524242};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL arst_first_hdr got=%h want=%h", obs, exp); end
    step();
    step();
    exp = {4'b0001, 2'b11, 32'h00050009};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL arst_first_br got=%h want=%h", obs, exp); end
    req = '0;
    step();
  endtask

  initial begin
    req        = '0;
    req_id     = '0;
    req_box    = '0;
    fifo_usedw = '0;
    fifo_flush = 1'b0;
    reset_n    = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_fifo_full();
    test_empty_box();
    test_flush_tl();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
